// File: rtl/gt_tx_arbiter.sv
// Round-robin scheduler sharing one GTX TX lane between NUM_REQ packet sources.
// Optional watchdog abort is built when GT_TX_ARB_WATCHDOG_EN is defined.
module gt_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LEN_W       = 16,
  parameter int TYPE_W      = 8,
  parameter int DATA_W      = 32,
  parameter int MAX_LEN     = 1024,
  parameter int GAP_CYCLES  = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                         tx_clk,
  input  logic                         rst_n,
  input  logic                         link_ready,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*LEN_W-1:0]     req_len,
  input  logic [NUM_REQ*TYPE_W-1:0]    req_type,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_data_rd,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [NUM_REQ-1:0]           req_reject,
  output logic                         tx_packet_req,
  output logic [LEN_W-1:0]             tx_packet_len,
  output logic [TYPE_W-1:0]            tx_packet_type,
  output logic [DATA_W-1:0]            tx_packet_data,
  input  logic                         tx_packet_data_rd,
  input  logic                         tx_packet_done,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic [31:0]                  pkt_cnt,
  output logic [15:0]                  abort_cnt,
  output logic                         wdog_err,
  output logic [1:0]                   dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  // Handshake: a source raises req_valid with len/type stable and holds it until
  // it sees req_done or req_reject; while granted, each req_data_rd pulse consumes
  // the word on req_data and the source must present the next word next cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   rr_ptr;
  logic [GAP_W-1:0]   gap_cnt;

  logic               hi_found, lo_found, pick_found, pick_bad;
  logic [IDX_W-1:0]   hi_idx, lo_idx, pick_idx;
  logic [LEN_W-1:0]   pick_len;
  logic [TYPE_W-1:0]  pick_type;

  logic               send_done, send_abort, gap_last, wdog_hit;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Round-robin pick: lowest valid index at or above the pointer, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    pick_found = hi_found | lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    pick_len  = '0;
    pick_type = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        pick_len  = req_len[i*LEN_W +: LEN_W];
        pick_type = req_type[i*TYPE_W +: TYPE_W];
      end
    end
    pick_bad = (pick_len == '0) || ({1'b0, pick_len} > (LEN_W+1)'(MAX_LEN));
  end

  // A done pulse in the same cycle as a link drop or timeout still completes the packet.
  assign send_done  = (state == S_SEND) && tx_packet_done;
  assign send_abort = (state == S_SEND) && !tx_packet_done && (!link_ready || wdog_hit);
  assign gap_last   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (link_ready && (|req_valid)) state_n = S_ARB;
      S_ARB: begin
        if (!link_ready || !pick_found) state_n = S_IDLE;
        else if (pick_bad)              state_n = S_GAP;
        else                            state_n = S_SEND;
      end
      S_SEND: if (send_done || send_abort) state_n = S_GAP;
      S_GAP:  if (gap_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      grant_id       <= '0;
      tx_packet_len  <= '0;
      tx_packet_type <= '0;
      req_done       <= '0;
      req_reject     <= '0;
      pkt_cnt        <= '0;
      abort_cnt      <= '0;
      gap_cnt        <= '0;
    end else begin
      req_done   <= '0;
      req_reject <= '0;
      if (state == S_ARB && link_ready && pick_found) begin
        grant_id       <= pick_idx;
        tx_packet_len  <= pick_len;
        tx_packet_type <= pick_type;
        if (pick_bad) begin
          req_reject <= one_hot(pick_idx);
          rr_ptr     <= idx_inc(pick_idx);
        end
      end
      if (send_done) begin
        req_done <= one_hot(grant_id);
        pkt_cnt  <= pkt_cnt + 32'd1;
        rr_ptr   <= idx_inc(grant_id);
      end
      // Aborted source keeps requesting; moving past it lets others go first.
      if (send_abort) begin
        if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
        rr_ptr <= idx_inc(grant_id);
      end
      gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
    end
  end

  always_comb begin
    tx_packet_req  = (state == S_SEND);
    busy           = (state != S_IDLE);
    dbg_state      = state;
    tx_packet_data = '0;
    req_data_rd    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tx_packet_req && IDX_W'(i) == grant_id) begin
        tx_packet_data = req_data[i*DATA_W +: DATA_W];
        req_data_rd[i] = tx_packet_data_rd;
      end
    end
  end

`ifdef GT_TX_ARB_WATCHDOG_EN
  logic [31:0] wdog_cnt;

  assign wdog_hit = (state == S_SEND) && (wdog_cnt == 32'(WDOG_CYCLES - 1));

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= wdog_hit && !tx_packet_done;
      if (state == S_ARB)       wdog_cnt <= '0;
      else if (state == S_SEND) wdog_cnt <= wdog_cnt + 32'd1;
    end
  end
`else
  assign wdog_hit = 1'b0;
  // The limit only matters when the watchdog is built; this keeps the error low.
  assign wdog_err = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_gt_tx_arbiter.sv
// Directed bench for gt_tx_arbiter: single packet, fairness, reset, rejects,
// link drop with re-service, and stray done pulses.
module tb_gt_tx_arbiter;

  logic          tx_clk = 1'b0;
  logic          rst_n;
  logic          link_ready;
  logic [3:0]    req_valid;
  logic [63:0]   req_len;
  logic [31:0]   req_type;
  logic [127:0]  req_data;
  logic [3:0]    req_data_rd, req_done, req_reject;
  logic          tx_packet_req;
  logic [15:0]   tx_packet_len;
  logic [7:0]    tx_packet_type;
  logic [31:0]   tx_packet_data;
  logic          tx_packet_data_rd, tx_packet_done;
  logic [1:0]    grant_id;
  logic          busy;
  logic [31:0]   pkt_cnt;
  logic [15:0]   abort_cnt;
  logic          wdog_err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt[4];
  int done_cnt[4];
  int rise_cnt = 0;
  logic prev_req = 1'b0;
  logic force_done = 1'b0;
  logic [57:0] exp_q[$];
  logic [57:0] got_q[$];

  gt_tx_arbiter dut (
    .tx_clk(tx_clk), .rst_n(rst_n), .link_ready(link_ready),
    .req_valid(req_valid), .req_len(req_len), .req_type(req_type), .req_data(req_data),
    .req_data_rd(req_data_rd), .req_done(req_done), .req_reject(req_reject),
    .tx_packet_req(tx_packet_req), .tx_packet_len(tx_packet_len),
    .tx_packet_type(tx_packet_type), .tx_packet_data(tx_packet_data),
    .tx_packet_data_rd(tx_packet_data_rd), .tx_packet_done(tx_packet_done),
    .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt), .abort_cnt(abort_cnt),
    .wdog_err(wdog_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 tx_clk = ~tx_clk;

  function automatic logic [31:0] src_data(input int i);
    return 32'hD0D0_0000 + 32'(i);
  endfunction

  function automatic logic [57:0] tup(input int id, input int len, input int typ);
    return {2'(id), 16'(len), 8'(typ), src_data(id)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic wait_req_rise(input int budget);
    int n = 0;
    while (!tx_packet_req && n < budget) begin step(); n++; end
    check("req_wait", tx_packet_req, 1);
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (!req_done[i] && n < budget) begin step(); n++; end
    check($sformatf("done_wait%0d", i), req_done[i], 1);
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s_%0d", tag, k), 64'(got_q[k]), 64'(exp_q[k]));
  endtask

  // packet sender model: one rd per word, then a done pulse
  initial begin
    int words = 0;
    tx_packet_data_rd = 1'b0;
    tx_packet_done    = 1'b0;
    forever begin
      step();
      tx_packet_data_rd = 1'b0;
      tx_packet_done    = force_done;
      if (!rst_n || !tx_packet_req) words = 0;
      else if (words < int'(tx_packet_len)) begin
        tx_packet_data_rd = 1'b1;
        words++;
      end else tx_packet_done = 1'b1;
    end
  end

  // output monitor, sampled on the falling edge
  always @(negedge tx_clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rd_cnt[i]   += int'(req_data_rd[i]);
        done_cnt[i] += int'(req_done[i]);
      end
      if (tx_packet_req && !prev_req) begin
        rise_cnt++;
        got_q.push_back({grant_id, tx_packet_len, tx_packet_type, tx_packet_data});
      end
    end
    prev_req = tx_packet_req;
  end

  initial begin
    int n;
    int served[4];
    int rd_snap;
    int rise_snap;
    rst_n = 1'b0; link_ready = 1'b0; req_valid = '0;
    req_len = '0; req_type = '0; req_data = '0;
    for (int i = 0; i < 4; i++) begin
      rd_cnt[i] = 0; done_cnt[i] = 0; served[i] = 0;
      req_data[i*32 +: 32] = src_data(i);
    end

    // reset state
    repeat (3) step();
    check("rst_req", tx_packet_req, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_cnts", {pkt_cnt, abort_cnt}, 0);
    check("rst_strobes", {req_data_rd, req_done, req_reject, wdog_err}, 0);
    check("rst_pkt", {tx_packet_len, tx_packet_type, tx_packet_data}, 0);
    rst_n = 1'b1; link_ready = 1'b1;
    step();

    // single source, 256 words
    req_len[0 +: 16] = 16'd256; req_type[0 +: 8] = 8'd8; req_valid[0] = 1'b1;
    step();
    check("lat_arb_req", tx_packet_req, 0);
    check("lat_arb_busy", busy, 1);
    step();
    check("lat_send_req", tx_packet_req, 1);
    check("single_hdr", {grant_id, tx_packet_len, tx_packet_type}, {2'd0, 16'd256, 8'd8});
    check("single_data", tx_packet_data, src_data(0));
    wait_done(0, 400);
    req_valid[0] = 1'b0;
    check("single_pkt_cnt", pkt_cnt, 1);
    n = 0;
    while (busy && n < 20) begin n++; step(); end
    check("gap_cycles", n, 4);
    check("single_rd", rd_cnt[0], 256);
    check("single_done", done_cnt[0], 1);

    // reset mid-SEND; pointer is 1 after serving source 0
    for (int i = 0; i < 4; i++) begin
      req_len[i*16 +: 16] = 16'(i + 3);
      req_type[i*8 +: 8]  = 8'(8'h10 + i);
    end
    req_valid = 4'b1111;
    wait_req_rise(10);
    check("rr_after_single", grant_id, 1);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", tx_packet_req, 0);
    check("async_rst_busy", {busy, dbg_state}, 0);
    check("async_rst_out", {grant_id, pkt_cnt, req_data_rd, tx_packet_len}, 0);
    step(); step();
    rst_n = 1'b1;
    got_q.delete();

    // fairness: 3 packets each, first grant to lowest index
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) exp_q.push_back(tup(i, i + 3, 8'h10 + i));
    for (int cyc = 0; cyc < 2000 && (req_valid != 0 || busy); cyc++) begin
      step();
      for (int i = 0; i < 4; i++)
        if (req_done[i]) begin
          served[i]++;
          if (served[i] == 3) req_valid[i] = 1'b0;
        end
    end
    check("fair_end", req_valid, 0);
    check("fair_pkt_cnt", pkt_cnt, 12);
    compare_queues("fair_order");

    // illegal lengths on source 2
    rise_snap = rise_cnt;
    req_len[32 +: 16] = 16'd0; req_valid = 4'b0100;
    step(); step();
    check("rej_len0", req_reject, 4'b0100);
    req_len[32 +: 16] = 16'd1025;
    step();
    check("rej_pulse_width", req_reject, 0);
    n = 0;
    while (req_reject == 0 && n < 20) begin step(); n++; end
    check("rej_len1025", req_reject, 4'b0100);
    check("rej_latch", {grant_id, tx_packet_len}, {2'd2, 16'd1025});
    req_valid = 4'b0000;
    check("rej_no_req", rise_cnt, rise_snap);
    check("rej_abort_cnt", abort_cnt, 0);
    n = 0;
    while (busy && n < 20) begin step(); n++; end

    // link drop at word 100 of source 1
    for (int i = 0; i < 4; i++) begin rd_cnt[i] = 0; done_cnt[i] = 0; end
    req_len[0 +: 16] = 16'd4; req_len[16 +: 16] = 16'd200; req_len[48 +: 16] = 16'd4;
    req_valid = 4'b1010;
    wait_req_rise(20);
    check("ptr_after_reject", grant_id, 3);
    wait_done(3, 100);
    req_valid[3] = 1'b0;
    wait_req_rise(20);
    check("drop_grant", grant_id, 1);
    n = 0;
    while (rd_cnt[1] < 100 && n < 300) begin step(); n++; end
    link_ready = 1'b0;
    step();
    check("drop_req_low", tx_packet_req, 0);
    check("drop_abort_cnt", abort_cnt, 1);
    check("drop_pkt_cnt", pkt_cnt, 13);
    rd_snap = rd_cnt[1];
    rise_snap = rise_cnt;
    req_valid[0] = 1'b1;
    repeat (10) step();
    check("link_down_idle", {busy, tx_packet_req}, 0);
    check("link_down_no_grant", rise_cnt, rise_snap);
    check("drop_no_done", done_cnt[1], 0);

    got_q.delete(); exp_q.delete();
    exp_q.push_back(tup(0, 4, 8'h10));
    exp_q.push_back(tup(1, 200, 8'h11));
    link_ready = 1'b1;
    wait_done(0, 100);
    req_valid[0] = 1'b0;
    wait_req_rise(20);
    repeat (5) step();
    req_len[16 +: 16] = 16'd7; req_type[8 +: 8] = 8'hEE;
    step();
    check("len_stable", {tx_packet_len, tx_packet_type}, {16'd200, 8'h11});
    check("resend_data", tx_packet_data, src_data(1));
    wait_done(1, 400);
    req_valid[1] = 1'b0;
    step(); step();
    check("resend_rd", rd_cnt[1] - rd_snap, 200);
    check("resend_done", done_cnt[1], 1);
    check("resend_cnts", {pkt_cnt, abort_cnt}, {32'd15, 16'd1});
    compare_queues("resend_order");

    // done pulse outside SEND is ignored
    repeat (6) step();
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    repeat (3) step();
    check("stray_done_cnt", pkt_cnt, 15);
    check("stray_done_idle", {busy, req_done}, 0);
    check("wdog_off", wdog_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
